// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with bubble insertion, flush and a saturating bubble counter.
// Optional multi-cycle accumulate feedback path is enabled by defining EX_MEM_MADD_EN.
module ex_mem_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [RADDR_W-1:0]  ex_wd,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_wreg,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [1:0]          cnt_i,
  output logic                mem_valid,
  output logic [RADDR_W-1:0]  mem_wd,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wreg,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam logic [CNT_W-1:0] BC_MAX = '1;

  logic ex_stall;
  logic mem_stall;
  logic bubble;

  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];
  assign bubble    = ex_stall & ~mem_stall;

  // Only EX and MEM stall bits matter to this stage
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_valid  <= 1'b0;
      mem_wd     <= '0;
      mem_wdata  <= '0;
      mem_wreg   <= 1'b0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_wd     <= '0;
      mem_wdata  <= '0;
      mem_wreg   <= 1'b0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
    end else if (bubble) begin
      mem_valid  <= 1'b0;
      mem_wd     <= '0;
      mem_wdata  <= '0;
      mem_wreg   <= 1'b0;
      mem_whilo  <= 1'b0;
      mem_hi     <= '0;
      mem_lo     <= '0;
      if (bubble_cnt != BC_MAX)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (!ex_stall) begin
      mem_valid  <= ex_valid;
      mem_wd     <= ex_wd;
      mem_wdata  <= ex_wdata;
      mem_wreg   <= ex_wreg & ex_valid;
      mem_whilo  <= ex_whilo & ex_valid;
      mem_hi     <= ex_hi;
      mem_lo     <= ex_lo;
    end
  end

`ifdef EX_MEM_MADD_EN
  // Partial product survives only while EX is held by a bubble
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (bubble) begin
      hilo_temp_o <= hilo_temp_i;
      cnt_o       <= cnt_i;
    end else if (!ex_stall) begin
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end
`else
  assign hilo_temp_o = '0;
  assign cnt_o       = '0;

  logic unused_madd;
  assign unused_madd = ^{hilo_temp_i, cnt_i};
`endif

endmodule
